// File: rtl/coherence_emitter_multiline.sv
// Direct-mapped MSI/MESI coherence controller: NUM_LINES lines, bus req/grant, snoop handling.
// Latency: hit responds 1 cycle after accept; a miss responds 1 cycle after its last grant.
// Backpressure: req_ready only in IDLE; bus_req/bus_msg/bus_addr are held until bus_grant.
//
// Ports:
//   clock, resetn                       - rising-edge clock, async active-low reset
//   req_valid/req_write/req_addr        - CPU request; accepted when req_valid && req_ready
//   req_ready, resp_valid, resp_hit     - request handshake and one-cycle completion pulse
//   bus_req/bus_grant/bus_msg/bus_addr  - shared-bus arbitration and issued message
//   bus_shared                          - sampled when a READ_MISS is granted
//   snoop_valid/snoop_msg/snoop_addr    - other caches' bus traffic
//   snoop_wb                            - pulse: a local M line must be flushed for a snoop
module coherence_emitter_multiline #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 8,
  parameter bit MESI_EN   = 1'b0
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic                                   req_valid,
  input  logic                                   req_write,
  input  logic [TAG_W+$clog2(NUM_LINES)-1:0]     req_addr,
  output logic                                   req_ready,
  output logic                                   resp_valid,
  output logic                                   resp_hit,
  output logic                                   bus_req,
  input  logic                                   bus_grant,
  output logic [2:0]                             bus_msg,
  output logic [TAG_W+$clog2(NUM_LINES)-1:0]     bus_addr,
  input  logic                                   bus_shared,
  input  logic                                   snoop_valid,
  input  logic [2:0]                             snoop_msg,
  input  logic [TAG_W+$clog2(NUM_LINES)-1:0]     snoop_addr,
  output logic                                   snoop_wb
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int ADDR_W = TAG_W + IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;
  localparam logic [1:0] ST_E = 2'b11;

  localparam logic [2:0] MSG_NONE = 3'b000;
  localparam logic [2:0] MSG_WM   = 3'b001;
  localparam logic [2:0] MSG_RM   = 3'b010;
  localparam logic [2:0] MSG_INV  = 3'b011;
  localparam logic [2:0] MSG_WB   = 3'b100;

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_WB   = 2'd1;
  localparam logic [1:0] FSM_BUS  = 2'd2;
  localparam logic [1:0] FSM_RESP = 2'd3;

  logic [1:0]       line_st  [NUM_LINES];
  logic [TAG_W-1:0] line_tag [NUM_LINES];
  logic [1:0]       fsm;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]       r_msg;
  logic             r_hit;

  logic [IDX_W-1:0] r_idx, q_idx, s_idx;
  logic [TAG_W-1:0] r_tag, q_tag, s_tag;
  logic [1:0]       q_st, s_st;
  logic             q_hit, grant_act, s_hit, s_kill, s_rd;

  assign r_idx = r_addr[IDX_W-1:0];
  assign r_tag = r_addr[ADDR_W-1:IDX_W];
  assign q_idx = req_addr[IDX_W-1:0];
  assign q_tag = req_addr[ADDR_W-1:IDX_W];
  assign s_idx = snoop_addr[IDX_W-1:0];
  assign s_tag = snoop_addr[ADDR_W-1:IDX_W];

  assign q_st  = line_st[q_idx];
  assign s_st  = line_st[s_idx];
  assign q_hit = (q_st != ST_I) && (line_tag[q_idx] == q_tag);

  assign grant_act = bus_req && bus_grant;

  // A snoop coinciding with our own grant is dropped so the grant update is never overridden.
  assign s_hit  = snoop_valid && !grant_act && (s_st != ST_I) && (line_tag[s_idx] == s_tag);
  assign s_kill = s_hit && ((snoop_msg == MSG_WM) || (snoop_msg == MSG_INV));
  assign s_rd   = s_hit && (snoop_msg == MSG_RM);

  assign snoop_wb   = (s_kill || s_rd) && (s_st == ST_M);
  assign req_ready  = (fsm == FSM_IDLE);
  assign resp_valid = (fsm == FSM_RESP);
  assign resp_hit   = (fsm == FSM_RESP) && r_hit;
  assign bus_req    = (fsm == FSM_WB) || (fsm == FSM_BUS);

  always_comb begin
    bus_msg  = MSG_NONE;
    bus_addr = '0;
    if (fsm == FSM_WB) begin
      bus_msg  = MSG_WB;
      bus_addr = {line_tag[r_idx], r_idx};
    end else if (fsm == FSM_BUS) begin
      bus_msg  = r_msg;
      bus_addr = r_addr;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_st[i]  <= ST_I;
        line_tag[i] <= '0;
      end
      fsm    <= FSM_IDLE;
      r_addr <= '0;
      r_msg  <= MSG_NONE;
      r_hit  <= 1'b0;
    end else begin
      // Snoop updates first; the local FSM updates below take precedence on the same line.
      if (s_kill) begin
        line_st[s_idx] <= ST_I;
      end else if (s_rd) begin
        line_st[s_idx] <= ST_S;
      end

      case (fsm)
        FSM_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            if (q_hit && (!req_write || q_st == ST_M)) begin
              r_hit <= 1'b1;
              fsm   <= FSM_RESP;
            end else if (q_hit && MESI_EN && q_st == ST_E) begin
              // Silent upgrade: exclusive ownership means no bus traffic is needed.
              line_st[q_idx] <= ST_M;
              r_hit          <= 1'b1;
              fsm            <= FSM_RESP;
            end else if (q_hit) begin
              r_msg <= MSG_INV;
              fsm   <= FSM_BUS;
            end else begin
              r_msg <= req_write ? MSG_WM : MSG_RM;
              fsm   <= (q_st == ST_M) ? FSM_WB : FSM_BUS;
            end
          end
        end
        FSM_WB: begin
          if (grant_act) begin
            line_st[r_idx] <= ST_I;
            fsm            <= FSM_BUS;
          end else if (snoop_wb && (s_idx == r_idx)) begin
            // The snoop's flush already wrote the victim back; skip our own WRITEBACK.
            fsm <= FSM_BUS;
          end
        end
        FSM_BUS: begin
          if (grant_act) begin
            line_tag[r_idx] <= r_tag;
            if (r_msg == MSG_RM) begin
              line_st[r_idx] <= (MESI_EN && !bus_shared) ? ST_E : ST_S;
            end else begin
              line_st[r_idx] <= ST_M;
            end
            r_hit <= (r_msg == MSG_INV);
            fsm   <= FSM_RESP;
          end else if ((r_msg == MSG_INV) && s_kill && (s_idx == r_idx)) begin
            // Our shared copy was taken away; the upgrade becomes a full write miss.
            r_msg <= MSG_WM;
          end
        end
        default: begin
          fsm <= FSM_IDLE;
        end
      endcase
    end
  end

endmodule
